uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_if.sv | 25 ++
 rtl/uart_tx_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake bundle for uart_tx_sched.
// Each requester i presents req_valid[i] and a byte in req_data[8i+7:8i];
// the scheduler answers with a one-hot req_ready accept strobe.
interface uart_tx_sched_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;

    // Requesters drive valid/data and observe ready
    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    // Scheduler observes valid/data and drives ready
    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler feeding a single UART transmitter.
// Frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Each line level is launched on a txclk_en tick and held until the next one.
// Optional feature: define UART_TX_SCHED_PARITY_EN to add the even-parity bit
// (11-period frame); without it the frame is 10 periods.
module uart_tx_sched #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       txclk_en,
    uart_tx_sched_if.slave             req,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic                 tx_q, tx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 accept;

    // Round-robin search: first valid requester after the last grant, wrapping
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!pick_found && req.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    // Accept strobe is only offered in IDLE and never while reset is asserted
    always_comb begin
        accept        = (state_q == S_IDLE) && !RST && pick_found;
        req.req_ready = accept ? (NUM_REQ'(1) << pick_idx) : '0;
    end

    // Frame sequencer: every transition past IDLE waits for a baud tick, so a
    // tick coinciding with acceptance is ignored and the stop bit gets a full period
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = req.req_data[pick_idx*DATA_BITS +: DATA_BITS];
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (txclk_en) begin
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (txclk_en) begin
                    tx_d = data_q[cnt_q];
                    if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            S_PARITY: begin
                if (txclk_en) begin
                    tx_d    = ^data_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (txclk_en) begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight and restores requester 0 priority
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        tx       = tx_q;
        busy     = (state_q != S_IDLE);
        grant_id = grant_q;
    end
endmodule
